// File: rtl/ftsr_result_checker.sv
// Redundant-issue result checker. It pairs the primary and shadow writeback
// results for each transaction ID and reports match or mismatch one cycle later.
package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned TRANS_ID_BITS;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd32, TRANS_ID_BITS: 32'd3};
endpackage

module ftsr_result_checker #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
  parameter int unsigned           CNT_WIDTH = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   cnt_clear_i,
  input  logic                                   pri_valid_i,
  input  logic [CVA6Cfg.TRANS_ID_BITS-1:0]       pri_trans_id_i,
  input  logic [CVA6Cfg.XLEN-1:0]                pri_result_i,
  input  logic                                   sh_valid_i,
  input  logic [CVA6Cfg.TRANS_ID_BITS-1:0]       sh_trans_id_i,
  input  logic [CVA6Cfg.XLEN-1:0]                sh_result_i,
  output logic                                   chk0_valid_o,
  output logic [CVA6Cfg.TRANS_ID_BITS-1:0]       chk0_trans_id_o,
  output logic                                   chk0_match_o,
  output logic                                   chk1_valid_o,
  output logic [CVA6Cfg.TRANS_ID_BITS-1:0]       chk1_trans_id_o,
  output logic                                   chk1_match_o,
  output logic [(2**CVA6Cfg.TRANS_ID_BITS)-1:0]  pending_o,
  output logic                                   proto_err_o,
  output logic [CNT_WIDTH-1:0]                   mismatch_cnt_o
);
  localparam int unsigned XLEN = CVA6Cfg.XLEN;
  localparam int unsigned TB   = CVA6Cfg.TRANS_ID_BITS;
  localparam int unsigned NENT = 2**TB;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [NENT-1:0]      held_q, held_d;
  logic [NENT-1:0]      side_q, side_d;
  logic [XLEN-1:0]      data_q [NENT];
  logic                 pri_wr_s, sh_wr_s, same_id_s;
  logic                 chk0_valid_q, chk0_valid_d, chk0_match_q, chk0_match_d;
  logic                 chk1_valid_q, chk1_valid_d, chk1_match_q, chk1_match_d;
  logic [TB-1:0]        chk0_id_q, chk0_id_d, chk1_id_q, chk1_id_d;
  logic                 proto_err_q, proto_err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           n_mis_s;
  logic [CNT_WIDTH+1:0] cnt_sum_s;

  assign same_id_s = pri_valid_i & sh_valid_i & (pri_trans_id_i == sh_trans_id_i);

  always_comb begin
    held_d       = held_q;
    side_d       = side_q;
    pri_wr_s     = 1'b0;
    sh_wr_s      = 1'b0;
    chk0_valid_d = 1'b0;
    chk0_id_d    = '0;
    chk0_match_d = 1'b0;
    chk1_valid_d = 1'b0;
    chk1_id_d    = '0;
    chk1_match_d = 1'b0;
    proto_err_d  = 1'b0;
    if (flush_i) begin
      held_d = '0;
    end else if (same_id_s) begin
      // Both copies in one cycle: compare inputs directly, table untouched.
      if (!held_q[pri_trans_id_i]) begin
        chk0_valid_d = 1'b1;
        chk0_id_d    = pri_trans_id_i;
        chk0_match_d = (pri_result_i == sh_result_i);
      end else begin
        proto_err_d = 1'b1;
      end
    end else begin
      if (pri_valid_i) begin
        if (!held_q[pri_trans_id_i]) begin
          held_d[pri_trans_id_i] = 1'b1;
          side_d[pri_trans_id_i] = 1'b0;
          pri_wr_s               = 1'b1;
        end else if (side_q[pri_trans_id_i]) begin
          held_d[pri_trans_id_i] = 1'b0;
          chk0_valid_d           = 1'b1;
          chk0_id_d              = pri_trans_id_i;
          chk0_match_d           = (pri_result_i == data_q[pri_trans_id_i]);
        end else begin
          proto_err_d = 1'b1;
        end
      end else begin
        pri_wr_s = 1'b0;
      end
      if (sh_valid_i) begin
        if (!held_q[sh_trans_id_i]) begin
          held_d[sh_trans_id_i] = 1'b1;
          side_d[sh_trans_id_i] = 1'b1;
          sh_wr_s               = 1'b1;
        end else if (!side_q[sh_trans_id_i]) begin
          held_d[sh_trans_id_i] = 1'b0;
          chk1_valid_d          = 1'b1;
          chk1_id_d             = sh_trans_id_i;
          chk1_match_d          = (sh_result_i == data_q[sh_trans_id_i]);
        end else begin
          proto_err_d = 1'b1;
        end
      end else begin
        sh_wr_s = 1'b0;
      end
    end
  end

  assign n_mis_s   = {1'b0, chk0_valid_d & ~chk0_match_d} + {1'b0, chk1_valid_d & ~chk1_match_d};
  assign cnt_sum_s = {2'b00, cnt_q} + {{CNT_WIDTH{1'b0}}, n_mis_s};

  always_comb begin
    if (cnt_clear_i) begin
      cnt_d = '0;
    end else if (cnt_sum_s > {2'b00, CNT_MAX}) begin
      cnt_d = CNT_MAX;
    end else begin
      cnt_d = cnt_sum_s[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_q       <= '0;
      side_q       <= '0;
      chk0_valid_q <= 1'b0;
      chk0_id_q    <= '0;
      chk0_match_q <= 1'b0;
      chk1_valid_q <= 1'b0;
      chk1_id_q    <= '0;
      chk1_match_q <= 1'b0;
      proto_err_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      held_q       <= held_d;
      side_q       <= side_d;
      chk0_valid_q <= chk0_valid_d;
      chk0_id_q    <= chk0_id_d;
      chk0_match_q <= chk0_match_d;
      chk1_valid_q <= chk1_valid_d;
      chk1_id_q    <= chk1_id_d;
      chk1_match_q <= chk1_match_d;
      proto_err_q  <= proto_err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Primary and shadow never write the same entry in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NENT); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (pri_wr_s) begin
        data_q[pri_trans_id_i] <= pri_result_i;
      end
      if (sh_wr_s) begin
        data_q[sh_trans_id_i] <= sh_result_i;
      end
    end
  end

  assign chk0_valid_o    = chk0_valid_q;
  assign chk0_trans_id_o = chk0_id_q;
  assign chk0_match_o    = chk0_match_q;
  assign chk1_valid_o    = chk1_valid_q;
  assign chk1_trans_id_o = chk1_id_q;
  assign chk1_match_o    = chk1_match_q;
  assign pending_o       = held_q;
  assign proto_err_o     = proto_err_q;
  assign mismatch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_ftsr_result_checker.sv
// Bench for ftsr_result_checker: directed vector table, reset corner case,
// then random traffic against a per-ID pairing reference model.
module tb_ftsr_result_checker;
  localparam int CMAX = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni, flush_i, cnt_clear_i, pri_valid_i, sh_valid_i;
  logic [2:0]  pri_trans_id_i, sh_trans_id_i;
  logic [31:0] pri_result_i, sh_result_i;
  logic        chk0_valid_o, chk0_match_o, chk1_valid_o, chk1_match_o, proto_err_o;
  logic [2:0]  chk0_trans_id_o, chk1_trans_id_o;
  logic [7:0]  pending_o;
  logic [1:0]  mismatch_cnt_o;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk_i = ~clk_i;

  ftsr_result_checker #(.CNT_WIDTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .cnt_clear_i(cnt_clear_i),
    .pri_valid_i(pri_valid_i), .pri_trans_id_i(pri_trans_id_i), .pri_result_i(pri_result_i),
    .sh_valid_i(sh_valid_i), .sh_trans_id_i(sh_trans_id_i), .sh_result_i(sh_result_i),
    .chk0_valid_o(chk0_valid_o), .chk0_trans_id_o(chk0_trans_id_o), .chk0_match_o(chk0_match_o),
    .chk1_valid_o(chk1_valid_o), .chk1_trans_id_o(chk1_trans_id_o), .chk1_match_o(chk1_match_o),
    .pending_o(pending_o), .proto_err_o(proto_err_o), .mismatch_cnt_o(mismatch_cnt_o)
  );

  typedef struct {
    logic fl, clr, pv; logic [2:0] pid; logic [31:0] pr;
    logic sv; logic [2:0] sid; logic [31:0] sr;
    logic c0v; logic [2:0] c0id; logic c0m;
    logic c1v; logic [2:0] c1id; logic c1m;
    logic perr; logic [7:0] pend; logic [1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic fl, input logic clr, input logic pv, input logic [2:0] pid, input logic [31:0] pr,
    input logic sv, input logic [2:0] sid, input logic [31:0] sr,
    input logic c0v, input logic [2:0] c0id, input logic c0m,
    input logic c1v, input logic [2:0] c1id, input logic c1m,
    input logic perr, input logic [7:0] pend, input logic [1:0] cnt);
    vec_t v;
    v.fl = fl; v.clr = clr; v.pv = pv; v.pid = pid; v.pr = pr;
    v.sv = sv; v.sid = sid; v.sr = sr;
    v.c0v = c0v; v.c0id = c0id; v.c0m = c0m;
    v.c1v = c1v; v.c1id = c1id; v.c1m = c1m;
    v.perr = perr; v.pend = pend; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag,
    input logic c0v, input logic [2:0] c0id, input logic c0m,
    input logic c1v, input logic [2:0] c1id, input logic c1m,
    input logic perr, input logic [7:0] pend, input logic [1:0] cnt);
    check({tag, " chk0_valid"}, 32'(chk0_valid_o), 32'(c0v));
    if (c0v) begin
      check({tag, " chk0_id"}, 32'(chk0_trans_id_o), 32'(c0id));
      check({tag, " chk0_match"}, 32'(chk0_match_o), 32'(c0m));
    end
    check({tag, " chk1_valid"}, 32'(chk1_valid_o), 32'(c1v));
    if (c1v) begin
      check({tag, " chk1_id"}, 32'(chk1_trans_id_o), 32'(c1id));
      check({tag, " chk1_match"}, 32'(chk1_match_o), 32'(c1m));
    end
    check({tag, " proto_err"}, 32'(proto_err_o), 32'(perr));
    check({tag, " pending"}, 32'(pending_o), 32'(pend));
    check({tag, " mismatch_cnt"}, 32'(mismatch_cnt_o), 32'(cnt));
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0; cnt_clear_i = 1'b0;
    pri_valid_i = 1'b0; pri_trans_id_i = 3'd0; pri_result_i = 32'd0;
    sh_valid_i = 1'b0; sh_trans_id_i = 3'd0; sh_result_i = 32'd0;
  endtask

  // Reference model: per-ID record of which copy is waiting and its value.
  logic        m_held [8];
  logic        m_side [8];
  logic [31:0] m_data [8];
  int          m_cnt;
  logic        e_c0v, e_c0m, e_c1v, e_c1m, e_perr;
  logic [2:0]  e_c0id, e_c1id;
  logic [7:0]  e_pend;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_held[i] = 1'b0; m_side[i] = 1'b0; m_data[i] = 32'd0;
    end
    m_cnt = 0;
  endtask

  task automatic model_arrive(input logic side, input logic [2:0] id, input logic [31:0] val);
    if (!m_held[id]) begin
      m_held[id] = 1'b1; m_side[id] = side; m_data[id] = val;
    end else if (m_side[id] == side) begin
      e_perr = 1'b1;
    end else begin
      m_held[id] = 1'b0;
      if (side == 1'b0) begin
        e_c0v = 1'b1; e_c0id = id; e_c0m = (val == m_data[id]);
      end else begin
        e_c1v = 1'b1; e_c1id = id; e_c1m = (val == m_data[id]);
      end
    end
  endtask

  task automatic model_step();
    int mis;
    e_c0v = 1'b0; e_c0m = 1'b0; e_c0id = 3'd0;
    e_c1v = 1'b0; e_c1m = 1'b0; e_c1id = 3'd0;
    e_perr = 1'b0;
    if (flush_i) begin
      for (int i = 0; i < 8; i++) m_held[i] = 1'b0;
    end else if (pri_valid_i && sh_valid_i && pri_trans_id_i == sh_trans_id_i) begin
      if (m_held[pri_trans_id_i]) e_perr = 1'b1;
      else begin
        e_c0v = 1'b1; e_c0id = pri_trans_id_i; e_c0m = (pri_result_i == sh_result_i);
      end
    end else begin
      if (pri_valid_i) model_arrive(1'b0, pri_trans_id_i, pri_result_i);
      if (sh_valid_i) model_arrive(1'b1, sh_trans_id_i, sh_result_i);
    end
    mis = int'(e_c0v && !e_c0m) + int'(e_c1v && !e_c1m);
    if (cnt_clear_i) m_cnt = 0;
    else m_cnt = (m_cnt + mis > CMAX) ? CMAX : m_cnt + mis;
    for (int i = 0; i < 8; i++) e_pend[i] = m_held[i];
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    check_outs("reset", 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'd0);
    rst_ni = 1'b1;
    model_clear();
  endtask

  initial begin
    // Directed vectors: inputs for one edge, outputs expected after it.
    //            fl    clr   pv    pid   pr          sv    sid   sr          c0v   id    m     c1v   id    m     perr  pend   cnt
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'd3, 32'hDEAD, 1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h08, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h08, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 32'h0,    1'b1, 3'd3, 32'hDEAD, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 8'h00, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'd5, 32'h1,    1'b1, 3'd5, 32'h2,    1'b1, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'd1, 32'hAA,   1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h02, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'd1, 32'hBB,   1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h02, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h02, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 32'h0,    1'b1, 3'd1, 32'hAA,   1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'd6, 32'h20,   1'b1, 3'd2, 32'h10,   1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h44, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'd2, 32'h11,   1'b1, 3'd6, 32'h21,   1'b1, 3'd2, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 2'd3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'd0, 32'h5,    1'b1, 3'd7, 32'h6,    1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h81, 2'd3));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 3'd4, 32'h9,    1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'd3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 32'h0,    1'b1, 3'd0, 32'h5,    1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h01, 2'd3));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h01, 2'd0));
    for (int k = 1; k <= 5; k++) begin
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'd5, 32'h1,  1'b1, 3'd5, 32'h2,    1'b1, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h01,
                        (k > 3) ? 2'd3 : 2'(k)));
    end
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'd5, 32'h1,    1'b1, 3'd5, 32'h2,    1'b1, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h01, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'd0, 32'h7,    1'b1, 3'd0, 32'h8,    1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h01, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'd0, 32'h5,    1'b0, 3'd0, 32'h0,    1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'd0));

    do_reset();
    foreach (vecs[i]) begin
      flush_i = vecs[i].fl; cnt_clear_i = vecs[i].clr;
      pri_valid_i = vecs[i].pv; pri_trans_id_i = vecs[i].pid; pri_result_i = vecs[i].pr;
      sh_valid_i = vecs[i].sv; sh_trans_id_i = vecs[i].sid; sh_result_i = vecs[i].sr;
      @(posedge clk_i);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].c0v, vecs[i].c0id, vecs[i].c0m,
                 vecs[i].c1v, vecs[i].c1id, vecs[i].c1m, vecs[i].perr, vecs[i].pend, vecs[i].cnt);
    end

    // Reset asserted while a mismatch pulse and a held entry are live.
    idle_inputs();
    pri_valid_i = 1'b1; pri_trans_id_i = 3'd4; pri_result_i = 32'h1;
    @(posedge clk_i);
    #1;
    idle_inputs();
    sh_valid_i = 1'b1; sh_trans_id_i = 3'd4; sh_result_i = 32'h2;
    pri_valid_i = 1'b1; pri_trans_id_i = 3'd6; pri_result_i = 32'h3;
    @(posedge clk_i);
    #1;
    idle_inputs();
    check_outs("midrst_pre", 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 8'h40, 2'd1);
    rst_ni = 1'b0;
    #1;
    check_outs("midrst_in", 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'd0);
    @(posedge clk_i);
    #1;
    do_reset();

    for (int c = 0; c < 3000; c++) begin
      flush_i        = ($urandom_range(0, 19) == 0);
      cnt_clear_i    = ($urandom_range(0, 15) == 0);
      pri_valid_i    = 1'($urandom_range(0, 1));
      sh_valid_i     = 1'($urandom_range(0, 1));
      pri_trans_id_i = 3'($urandom_range(0, (c % 2 == 0) ? 3 : 7));
      sh_trans_id_i  = 3'($urandom_range(0, (c % 2 == 0) ? 3 : 7));
      pri_result_i   = 32'($urandom_range(0, 2));
      sh_result_i    = 32'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) sh_result_i = $urandom;
      model_step();
      @(posedge clk_i);
      #1;
      check_outs("rnd", e_c0v, e_c0id, e_c0m, e_c1v, e_c1id, e_c1m, e_perr, e_pend, 2'(m_cnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
